// File: rtl/audio_clk_gen.sv
// Audio codec clock generator: derives BCLK/LRCLK and serializer strobes from the PLL clock once lock is qualified.
// Optional lock-loss counter is built only when AUDIO_CLK_GEN_LOSS_CNT_EN is defined.
module audio_clk_gen #(
  parameter int MCLK_DIV           = 4,
  parameter int BCLK_PER_FRAME     = 64,
  parameter int LOCK_STABLE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       enable,
  output logic       bclk,
  output logic       lrclk,
  output logic       bclk_fall,
  output logic       bclk_rise,
  output logic       frame_start,
  output logic       running,
  output logic [7:0] lock_lost_count
);

  localparam int DW = $clog2(MCLK_DIV);
  localparam int BW = $clog2(BCLK_PER_FRAME);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(MCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(MCLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BCLK_PER_FRAME - 1);
  localparam logic [BW-1:0] BIT_HALF  = BW'(BCLK_PER_FRAME / 2);
  localparam logic [SW-1:0] STAB_TGT  = SW'(LOCK_STABLE_CYCLES);

  // state       | meaning
  // S_IDLE      | clocks stopped, waiting for lock and enable
  // S_WAIT_STAB | counting consecutive locked cycles
  // S_RUN       | clocks running
  // S_DRAIN     | clocks running until the current frame ends
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_STAB = 2'd1;
  localparam logic [1:0] S_RUN       = 2'd2;
  localparam logic [1:0] S_DRAIN     = 2'd3;

  logic          r_lk_meta;
  logic          r_lk;
  logic [1:0]    r_state;
  logic [SW-1:0] r_stab_cnt;
  logic [DW-1:0] r_div_cnt;
  logic [BW-1:0] r_bit_cnt;

  logic [1:0]    w_nxt_state;
  logic [SW-1:0] w_nxt_stab;
  logic [DW-1:0] w_nxt_div;
  logic [BW-1:0] w_nxt_bit;
  logic [DW-1:0] w_div_adv;
  logic [BW-1:0] w_bit_adv;
  logic          w_frame_end;
  logic          w_run_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lk_meta <= 1'b0;
      r_lk      <= 1'b0;
    end else begin
      r_lk_meta <= pll_locked;
      r_lk      <= r_lk_meta;
    end
  end

  always_comb begin
    w_div_adv   = (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DW'(1);
    w_bit_adv   = r_bit_cnt;
    if (r_div_cnt == DIV_LAST)
      w_bit_adv = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + BW'(1);
    w_frame_end = (r_div_cnt == DIV_LAST) && (r_bit_cnt == BIT_LAST);
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_stab  = '0;
    w_nxt_div   = '0;
    w_nxt_bit   = '0;
    case (r_state)
      S_IDLE: begin
        if (r_lk && enable) begin
          w_nxt_state = S_WAIT_STAB;
          w_nxt_stab  = SW'(1);
        end
      end
      S_WAIT_STAB: begin
        if (!r_lk || !enable)
          w_nxt_state = S_IDLE;
        else if (r_stab_cnt == STAB_TGT)
          w_nxt_state = S_RUN;
        else
          w_nxt_stab  = r_stab_cnt + SW'(1);
      end
      S_RUN: begin
        if (!r_lk) begin
          w_nxt_state = S_IDLE;
        end else begin
          w_nxt_div = w_div_adv;
          w_nxt_bit = w_bit_adv;
          if (!enable)
            w_nxt_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Re-enable takes priority over the frame end so the timing never hiccups.
        if (!r_lk) begin
          w_nxt_state = S_IDLE;
        end else if (enable) begin
          w_nxt_state = S_RUN;
          w_nxt_div   = w_div_adv;
          w_nxt_bit   = w_bit_adv;
        end else if (w_frame_end) begin
          w_nxt_state = S_IDLE;
        end else begin
          w_nxt_div   = w_div_adv;
          w_nxt_bit   = w_bit_adv;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  assign w_run_nxt = (w_nxt_state == S_RUN) || (w_nxt_state == S_DRAIN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_stab_cnt  <= '0;
      r_div_cnt   <= '0;
      r_bit_cnt   <= '0;
      bclk        <= 1'b0;
      lrclk       <= 1'b0;
      bclk_fall   <= 1'b0;
      bclk_rise   <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_stab_cnt  <= w_nxt_stab;
      r_div_cnt   <= w_nxt_div;
      r_bit_cnt   <= w_nxt_bit;
      bclk        <= w_run_nxt && (w_nxt_div >= DIV_HALF);
      lrclk       <= w_run_nxt && (w_nxt_bit >= BIT_HALF);
      bclk_fall   <= w_run_nxt && (w_nxt_div == '0);
      bclk_rise   <= w_run_nxt && (w_nxt_div == DIV_HALF);
      frame_start <= w_run_nxt && (w_nxt_div == '0) && (w_nxt_bit == '0);
      running     <= w_run_nxt;
    end
  end

`ifdef AUDIO_CLK_GEN_LOSS_CNT_EN
  logic       w_loss;
  logic [7:0] r_loss_cnt;

  assign w_loss = ((r_state == S_RUN) || (r_state == S_DRAIN)) && !r_lk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_loss_cnt <= 8'd0;
    else if (w_loss && (r_loss_cnt != 8'hFF))
      r_loss_cnt <= r_loss_cnt + 8'd1;
  end

  assign lock_lost_count = r_loss_cnt;
`else
  assign lock_lost_count = 8'd0;
`endif

endmodule

// File: tb/tb_audio_clk_gen.sv
// Directed bench for audio_clk_gen with a 16-cycle lock qualification period.
module tb_audio_clk_gen;

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       enable;
  logic       bclk;
  logic       lrclk;
  logic       bclk_fall;
  logic       bclk_rise;
  logic       frame_start;
  logic       running;
  logic [7:0] lock_lost_count;

`ifdef AUDIO_CLK_GEN_LOSS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int errs;
  int n;
  int nf, nr, nfs;
  int cnt_254, cnt_255;

  audio_clk_gen #(
    .MCLK_DIV(4),
    .BCLK_PER_FRAME(64),
    .LOCK_STABLE_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pll_locked(pll_locked),
    .enable(enable),
    .bclk(bclk),
    .lrclk(lrclk),
    .bclk_fall(bclk_fall),
    .bclk_rise(bclk_rise),
    .frame_start(frame_start),
    .running(running),
    .lock_lost_count(lock_lost_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare outputs with the ideal waveform for cycle c counted from run start.
  task automatic cmp_cycle(input int c);
    int d, b;
    d = c % 4;
    b = (c / 4) % 64;
    if (bclk        !== (d >= 2))            errs++;
    if (lrclk       !== (b >= 32))           errs++;
    if (bclk_fall   !== (d == 0))            errs++;
    if (bclk_rise   !== (d == 2))            errs++;
    if (frame_start !== (d == 0 && b == 0))  errs++;
    if (running     !== 1'b1)                errs++;
  endtask

  task automatic wait_running(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (running) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_stopped(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (!running) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    enable     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bclk", bclk, 0);
    chk("rst_lrclk", lrclk, 0);
    chk("rst_running", running, 0);
    chk("rst_fall", bclk_fall, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_cnt", lock_lost_count, 0);

    reset_n = 1'b1;
    enable  = 1'b1;
    @(negedge clk);
    pll_locked = 1'b1;
    wait_running(n);
    chk("startup_latency", n, 19);
    chk("first_bclk", bclk, 0);
    chk("first_lrclk", lrclk, 0);
    chk("first_fall", bclk_fall, 1);
    chk("first_fs", frame_start, 1);

    errs = 0; nf = 0; nr = 0; nfs = 0;
    for (int c = 0; c < 768; c++) begin
      if (c > 0) @(negedge clk);
      cmp_cycle(c);
      nf  += int'(bclk_fall);
      nr  += int'(bclk_rise);
      nfs += int'(frame_start);
    end
    chk("three_frame_pattern", errs, 0);
    chk("fall_count", nf, 192);
    chk("rise_count", nr, 192);
    chk("fs_count", nfs, 3);

    errs = 0;
    for (int c = 768; c <= 808; c++) begin
      @(negedge clk);
      cmp_cycle(c);
    end
    enable = 1'b0;
    for (int c = 809; c <= 1023; c++) begin
      @(negedge clk);
      cmp_cycle(c);
    end
    chk("drain_pattern", errs, 0);
    @(negedge clk);
    chk("drain_stop_running", running, 0);
    chk("drain_stop_bclk", bclk, 0);
    chk("drain_stop_lrclk", lrclk, 0);
    repeat (5) @(negedge clk);
    chk("idle_hold_bclk", bclk, 0);
    chk("idle_hold_running", running, 0);

    enable = 1'b1;
    repeat (10) @(negedge clk);
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    pll_locked = 1'b1;
    wait_running(n);
    chk("requal_latency", n, 19);
    chk("qual_glitch_cnt", lock_lost_count, 0);

    repeat (100) @(negedge clk);
    pll_locked = 1'b0;
    wait_stopped(n);
    chk("loss_latency", n, 3);
    chk("loss_cnt_1", lock_lost_count, CNT_EN ? 32'd1 : 32'd0);
    chk("loss_bclk", bclk, 0);
    chk("loss_lrclk", lrclk, 0);

    pll_locked = 1'b1;
    wait_running(n);
    chk("relock_latency", n, 19);
    repeat (37) @(negedge clk);
    pll_locked = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_simul_running", running, 1);
    enable = 1'b0;
    wait_stopped(n);
    chk("simul_latency", n, 1);
    chk("loss_cnt_2", lock_lost_count, CNT_EN ? 32'd2 : 32'd0);
    enable = 1'b1;

    errs = 0; cnt_254 = -1; cnt_255 = -1;
    for (int i = 3; i <= 300; i++) begin
      pll_locked = 1'b1;
      wait_running(n);
      if (n != 19) errs++;
      repeat (5) @(negedge clk);
      pll_locked = 1'b0;
      wait_stopped(n);
      if (n != 3) errs++;
      if (i == 254) cnt_254 = int'(lock_lost_count);
      if (i == 255) cnt_255 = int'(lock_lost_count);
    end
    chk("loss_loop_timing", errs, 0);
    chk("cnt_at_254", cnt_254, CNT_EN ? 32'd254 : 32'd0);
    chk("cnt_at_255", cnt_255, CNT_EN ? 32'd255 : 32'd0);
    chk("cnt_saturated", lock_lost_count, CNT_EN ? 32'd255 : 32'd0);

    pll_locked = 1'b1;
    wait_running(n);
    chk("pre_reset_latency", n, 19);
    repeat (50) @(negedge clk);
    chk("pre_reset_bclk", bclk, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_running", running, 0);
    chk("async_rst_bclk", bclk, 0);
    chk("async_rst_cnt", lock_lost_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_running(n);
    chk("post_reset_latency", n, 19);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/audio_clk_gen.md
Name: audio_clk_gen

Overview:
- Consumer end of the audio PLL output: runs on the 12.288 MHz PLL clock and takes the PLL `locked` flag.
- Generates codec serial timing: BCLK (MCLK/4 = 3.072 MHz) and LRCLK (BCLK/64 = 48 kHz), plus single-cycle strobes for the I2S serializer/deserializer.
- Timing starts only after lock has been stable for a qualification period. It stops immediately on lock loss and stops gracefully, at a frame boundary, when disabled.

Parameters:
- MCLK_DIV, default 4: clk cycles per BCLK period; even, >=2.
- BCLK_PER_FRAME, default 64: BCLK periods per LRCLK frame; even, >=2.
- LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before starting; >=1.

Ports:
- clk, input, 1: PLL output clock (12.288 MHz); all logic on rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- pll_locked, input, 1: PLL lock flag, asynchronous to clk; double-flop synchronized internally.
- enable, input, 1: request to run clocks; synchronous.
- bclk, output, 1: bit clock, registered.
- lrclk, output, 1: word select; 0 = left, 1 = right; registered.
- bclk_fall, output, 1: one-cycle strobe in the cycle where bclk goes 1->0 (including the first low cycle of a run).
- bclk_rise, output, 1: one-cycle strobe in the cycle where bclk goes 0->1.
- frame_start, output, 1: one-cycle strobe coincident with the bclk_fall that begins bit 0 of a frame.
- running, output, 1: high in RUN and DRAIN.
- lock_lost_count, output, 8: saturating count of lock losses while running.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, synchronizer flops 0.
- Synchronizer: lk = pll_locked after 2 flops; 2-cycle input latency.
- States:
  - IDLE:
    - lk=1 and enable=1 -> WAIT_STABLE, stab_cnt=1.
  - WAIT_STABLE:
    - lk=0 -> IDLE, stab_cnt=0.
    - enable=0 -> IDLE.
    - stab_cnt==LOCK_STABLE_CYCLES -> RUN, div_cnt=0, bit_cnt=0.
    - Otherwise stab_cnt++.
  - RUN:
    - Counters advance every cycle.
    - enable=0 -> DRAIN (counters keep running).
    - lk=0 -> IDLE.
  - DRAIN:
    - Identical timing to RUN.
    - Goes to IDLE on the cycle after the last clk of the frame (bit_cnt==BCLK_PER_FRAME-1 and div_cnt==MCLK_DIV-1).
    - enable returning to 1 during DRAIN -> back to RUN with no timing disturbance.
    - lk=0 -> IDLE.
- Counters (RUN/DRAIN only):
  - div_cnt counts 0..MCLK_DIV-1 and wraps.
  - bit_cnt increments when div_cnt wraps; it wraps at BCLK_PER_FRAME-1 -> 0.
- Outputs (registered, reflecting the current counter values):
  - bclk = (div_cnt >= MCLK_DIV/2).
  - lrclk = (bit_cnt >= BCLK_PER_FRAME/2).
  - bclk_fall = (div_cnt==0).
  - bclk_rise = (div_cnt==MCLK_DIV/2).
  - frame_start = (div_cnt==0 && bit_cnt==0).
- First RUN cycle: bclk=0, lrclk=0, bclk_fall=1, frame_start=1, running=1.
- Outside RUN/DRAIN: bclk, lrclk, strobes and running are all 0. The transition to IDLE takes effect in the next cycle with no partial-glitch pulse.
- Lock loss:
  - If lk falls in RUN or DRAIN, running drops the cycle after lk is seen low, and the frame is truncated.
  - lock_lost_count increments by 1 on that transition and saturates at 255.
  - Loss in IDLE or WAIT_STABLE does not count.
- Simultaneous enable=0 and lk=0 in RUN: lock loss wins -> IDLE, count increments.
- Re-lock after a loss always requalifies through the full LOCK_STABLE_CYCLES.
- Asynchronous reset mid-frame clears everything, including lock_lost_count.

Optional Feature:
- Macro: AUDIO_CLK_GEN_LOSS_CNT_EN.
- Defined: lock_lost_count is implemented as above.
- Undefined: no counter register; lock_lost_count is tied to 8'd0. All other behaviour is unchanged.

Test Plan:
- Start-up: reset release, enable=1, pll_locked=1 held (LOCK_STABLE_CYCLES=16) -> running rises exactly 2+1+16 cycles after pll_locked. First cycle: bclk=0, frame_start=1. bclk period 4 clk at 50% duty; lrclk period 256 clk, high for clk 128..255 of each frame.
- Strobes: over 3 frames -> exactly 192 bclk_fall, 192 bclk_rise, 3 frame_start pulses. Each bclk_fall coincides with a bclk 1->0 change; frame_start coincides with an lrclk 1->0 change or with run start.
- Graceful stop: drop enable at frame bit 10 -> clocks continue through bit 63, last lrclk=1 cycle completes, running=0 on the next cycle, bclk/lrclk held 0.
- Lock glitch during qualification: pll_locked low for 3 cycles at stab_cnt=10 -> returns to IDLE, full 16-cycle requalification, lock_lost_count stays 0.
- Lock loss while running: pll_locked dropped mid-frame -> running=0 exactly 3 cycles later, lock_lost_count 0->1. Repeating 300 times -> count saturates at 255.
- Macro off: repeat the lock-loss test -> lock_lost_count stays 0 and all timing is identical.
